// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: SPI mode-0 peripheral in front of a NUM_REGS x DATA_W register file.
// Frame: R/W bit, ADDR_W address bits, DATA_W data bits, MSB first, sampled on sclk rise.
// SPI pins are oversampled in the clk domain; nothing is clocked by sclk.
// Optional feature macro: SPI_BURST_EN (multi-word frames with address auto-increment).
module spi_regfile_rw #(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int unsigned FRAME = 1 + ADDR_W + DATA_W;
`ifdef SPI_BURST_EN
  localparam int unsigned CNT_W   = 16;
  // Largest header-plus-whole-words count that fits in 16 bits.
  localparam int unsigned CNT_MAX = 1 + ADDR_W + ((65535 - 1 - ADDR_W) / DATA_W) * DATA_W;
  localparam int unsigned DBIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`else
  localparam int unsigned CNT_W   = $clog2(FRAME + 2);
  localparam int unsigned CNT_MAX = FRAME + 1;
`endif

  typedef enum logic [1:0] {StIdle, StCmd, StAddr, StData} state_e;

  state_e              state_q;
  logic [2:0]          sclk_sr;   // [1:0] synchroniser, [2] edge-detect stage
  logic [2:0]          ncs_sr;
  logic [1:0]          copi_sr;
  logic                sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s, active;
  logic [CNT_W-1:0]    count_q, count_nx;
  logic                rw_q, rw_nx;
  logic [ADDR_W-1:0]   addr_q, addr_nx;
  logic [DATA_W-1:0]   data_q, data_nx, tx_q, rd_word;
  logic                cipo_q, load_q, bit_ok, addr_ok;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
`ifdef SPI_BURST_EN
  logic [DBIT_W-1:0]   dbit_q, dbit_nx;
  logic                word_done, bad_q;
`endif

  // Synchronise the SPI pins into clk and keep one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr <= 3'b000;
      ncs_sr  <= 3'b111;
      copi_sr <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[1:0], sclk};
      ncs_sr  <= {ncs_sr[1:0], ncs};
      copi_sr <= {copi_sr[0], copi};
    end
  end

  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign ncs_rise  = ncs_sr[1] & ~ncs_sr[2];
  assign ncs_fall  = ~ncs_sr[1] & ncs_sr[2];
  assign copi_s    = copi_sr[1];
  // Uses the delayed ncs so a bit arriving with the ncs rise is still sampled.
  assign active    = ~ncs_sr[2] && (state_q != StIdle);
  assign addr_ok   = 32'(addr_q) < NUM_REGS;
  assign cipo_oe   = ~ncs_sr[1];
  assign cipo      = cipo_q & cipo_oe;

  // Readback mux; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (addr_q == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  // Next-state of the frame shifters for the current sclk rise (if any).
  always_comb begin
    count_nx = count_q;
    rw_nx    = rw_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    bit_ok   = 1'b0;
`ifdef SPI_BURST_EN
    dbit_nx   = dbit_q;
    word_done = 1'b0;
`endif
    if (active && sclk_rise && (count_q != CNT_W'(CNT_MAX))) begin
      bit_ok   = 1'b1;
      count_nx = count_q + CNT_W'(1);
      if (count_q == '0) begin
        rw_nx = copi_s;
      end else if (count_q <= CNT_W'(ADDR_W)) begin
        addr_nx = ADDR_W'({addr_q, copi_s});
      end else begin
        data_nx = DATA_W'({data_q, copi_s});
`ifdef SPI_BURST_EN
        if (dbit_q == DBIT_W'(DATA_W - 1)) begin
          dbit_nx   = '0;
          word_done = 1'b1;
          addr_nx   = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + ADDR_W'(1);
        end else begin
          dbit_nx = dbit_q + DBIT_W'(1);
        end
`endif
      end
    end
  end

  // Frame FSM, register file, commit/error strobes and cipo shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_q      <= '0;
      cipo_q    <= 1'b0;
      load_q    <= 1'b0;
      regs_q    <= '{default: '0};
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
`ifdef SPI_BURST_EN
      dbit_q    <= '0;
      bad_q     <= 1'b0;
`endif
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      load_q    <= 1'b0;
      if (ncs_fall) begin
        state_q <= StCmd;
        count_q <= '0;
        rw_q    <= 1'b0;
        addr_q  <= '0;
        data_q  <= '0;
        tx_q    <= '0;
        cipo_q  <= 1'b0;
`ifdef SPI_BURST_EN
        dbit_q  <= '0;
        bad_q   <= 1'b0;
`endif
      end else if (active) begin
        count_q <= count_nx;
        rw_q    <= rw_nx;
        addr_q  <= addr_nx;
        data_q  <= data_nx;
        if (bit_ok) begin
          if (count_q == '0) begin
            state_q <= StAddr;
          end else if (count_q == CNT_W'(ADDR_W)) begin
            state_q <= StData;
            load_q  <= ~rw_q;
          end
        end
`ifdef SPI_BURST_EN
        dbit_q <= dbit_nx;
        if (word_done) begin
          if (!rw_q) begin
            load_q <= 1'b1;
          end else if (addr_ok) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
              if (addr_q == ADDR_W'(i)) regs_q[i] <= data_nx;
            end
            wr_pulse <= 1'b1;
            wr_addr  <= addr_q;
          end else begin
            bad_q <= 1'b1;
          end
        end
`endif
        // Load lands well before the next sclk fall, so the two never collide.
        if (load_q) begin
          tx_q <= rd_word;
        end else if (sclk_fall) begin
          cipo_q <= tx_q[DATA_W-1];
          tx_q   <= tx_q << 1;
        end
        if (ncs_rise) begin
          state_q <= StIdle;
`ifdef SPI_BURST_EN
          if ((count_nx < CNT_W'(FRAME)) || (dbit_nx != '0) || bad_q ||
              (word_done && rw_nx && !addr_ok)) begin
            frame_err <= 1'b1;
          end
`else
          if (rw_nx) begin
            if ((count_nx == CNT_W'(FRAME)) && addr_ok) begin
              for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (addr_q == ADDR_W'(i)) regs_q[i] <= data_nx;
              end
              wr_pulse <= 1'b1;
              wr_addr  <= addr_q;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (count_nx != CNT_W'(FRAME)) begin
            frame_err <= 1'b1;
          end
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Bench for spi_regfile_rw: directed table, corner sequences and random frames
// checked against a register-array reference model.
module tb_spi_regfile_rw;
  localparam int NR   = 5;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int HALF = 5;   // clk cycles per sclk half period

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sclk = 1'b0;
  logic              ncs = 1'b1;
  logic              copi = 1'b0;
  logic              cipo, cipo_oe, wr_pulse, frame_err;
  logic [NR*DW-1:0]  regs_flat;
  logic [AW-1:0]     wr_addr;

  spi_regfile_rw #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_pulse = 0;
  int            n_err = 0;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] mregs [NR];

  // Strobe monitor on the falling edge, away from the bench's drive point.
  always @(negedge clk) begin
    if (wr_pulse) begin
      n_pulse = n_pulse + 1;
      last_wa = wr_addr;
    end
    if (frame_err) n_err = n_err + 1;
  end

  typedef struct {
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            n;
    int            ep;
    int            ee;
    logic [DW-1:0] erd;
    logic          crd;
  } vec_t;

  vec_t tbl [9];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] packm();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = mregs[i];
    return r;
  endfunction

  // Reference: frame of n bits carrying {rw, a, d}; updates mregs, returns expected strobes.
  function automatic void model(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int n, output int ep, output int ee,
                                output logic [DW-1:0] erd);
    int ai;
    ai  = int'(a);
    ep  = 0;
    ee  = 0;
    erd = '0;
    for (int i = 0; i < NR; i++) if (ai == i) erd = mregs[i];
    if (n < 16) begin
      ee = 1;
    end else if (n == 16) begin
      if (rw) begin
        if (ai < NR) begin
          ep = 1;
          for (int i = 0; i < NR; i++) if (ai == i) mregs[i] = d;
        end else begin
          ee = 1;
        end
      end
    end else begin
      ee = 1;
`ifdef SPI_BURST_EN
      if (rw && ai < NR) begin
        ep = 1;
        for (int i = 0; i < NR; i++) if (ai == i) mregs[i] = d;
      end
`endif
    end
  endfunction

  task automatic cs_low();
    ncs = 1'b0;
    tick(4);
    check("cipo_oe_selected", 64'(cipo_oe), 64'(1));
  endtask

  task automatic cs_high();
    tick(HALF);
    ncs = 1'b1;
    tick(8);
    check("cipo_oe_idle", 64'(cipo_oe), 64'(0));
    check("cipo_idle", 64'(cipo), 64'(0));
  endtask

  // Shift n bits of vec MSB first; record cipo just before each sclk rise.
  task automatic shift_bits(input logic [63:0] vec, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = vec[i];
      tick(HALF);
      rx = {rx[62:0], cipo};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int n, input int ep, input int ee, input logic [DW-1:0] erd,
                           input logic crd, input string tag);
    logic [63:0] base, vec, rx;
    base = 64'({rw, a, d});
    if (n <= 16) vec = base >> (16 - n);
    else vec = (base << (n - 16)) | 64'($urandom_range(0, 1));
    n_pulse = 0;
    n_err   = 0;
    cs_low();
    shift_bits(vec, n, rx);
    cs_high();
    check({tag, ".wr_pulses"}, 64'(n_pulse), 64'(ep));
    check({tag, ".frame_errs"}, 64'(n_err), 64'(ee));
    if (ep > 0) check({tag, ".wr_addr"}, 64'(last_wa), 64'(a));
    if (crd) check({tag, ".readback"}, 64'(rx[DW-1:0]), 64'(erd));
    check({tag, ".regs"}, 64'(regs_flat), 64'(packm()));
  endtask

  initial begin
    int            ep, ee;
    logic [DW-1:0] erd, d;
    logic [AW-1:0] a;
    logic          rw;
    int            n;
    logic [63:0]   rx;

    for (int i = 0; i < NR; i++) mregs[i] = '0;

    //            rw    addr   data   n   ep ee erd    crd
    tbl[0] = '{1'b1, 7'h02, 8'hA5, 16, 1, 0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 7'h04, 8'h3C, 16, 1, 0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 7'h04, 8'h00, 16, 0, 0, 8'h3C, 1'b1};
    tbl[3] = '{1'b1, 7'h01, 8'h77, 15, 0, 1, 8'h00, 1'b0};
`ifdef SPI_BURST_EN
    tbl[4] = '{1'b1, 7'h01, 8'h77, 17, 1, 1, 8'h00, 1'b0};
`else
    tbl[4] = '{1'b1, 7'h01, 8'h77, 17, 0, 1, 8'h00, 1'b0};
`endif
    tbl[5] = '{1'b1, 7'h05, 8'h99, 16, 0, 1, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 7'h05, 8'hFF, 16, 0, 0, 8'h00, 1'b1};
    tbl[7] = '{1'b0, 7'h02, 8'h00, 14, 0, 1, 8'h00, 1'b0};
    tbl[8] = '{1'b0, 7'h02, 8'h00, 16, 0, 0, 8'hA5, 1'b1};

    // Reset state
    tick(3);
    check("rst.regs", 64'(regs_flat), 64'(0));
    check("rst.cipo", 64'(cipo), 64'(0));
    check("rst.cipo_oe", 64'(cipo_oe), 64'(0));
    check("rst.wr_pulse", 64'(wr_pulse), 64'(0));
    check("rst.wr_addr", 64'(wr_addr), 64'(0));
    check("rst.frame_err", 64'(frame_err), 64'(0));
    rst = 1'b0;
    tick(4);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      model(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].n, ep, ee, erd);
      run_frame(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].n, tbl[i].ep, tbl[i].ee, tbl[i].erd,
                tbl[i].crd, $sformatf("tbl%0d", i));
    end

    // Final sclk rise coincides with ncs rise, then ncs falls again right after the commit
    n_pulse = 0;
    n_err   = 0;
    cs_low();
    shift_bits(64'({1'b1, 7'h02, 8'h5A}) >> 1, 15, rx);
    copi = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    ncs  = 1'b1;
    tick(1);
    sclk = 1'b0;
    ncs  = 1'b0;
    tick(6);
    ncs = 1'b1;
    tick(8);
    for (int i = 0; i < NR; i++) if (i == 2) mregs[i] = 8'h5A;
    check("simul.wr_pulses", 64'(n_pulse), 64'(1));
    check("simul.wr_addr", 64'(last_wa), 64'(2));
    check("simul.frame_errs", 64'(n_err), 64'(1));
    check("simul.regs", 64'(regs_flat), 64'(packm()));

    // Reset in the middle of a write frame
    n_pulse = 0;
    n_err   = 0;
    cs_low();
    shift_bits(64'({1'b1, 7'h03, 8'h42}) >> 6, 10, rx);
    rst  = 1'b1;
    ncs  = 1'b1;
    tick(2);
    check("midrst.regs", 64'(regs_flat), 64'(0));
    check("midrst.wr_pulses", 64'(n_pulse), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    tick(4);
    model(1'b1, 7'h03, 8'h42, 16, ep, ee, erd);
    run_frame(1'b1, 7'h03, 8'h42, 16, 1, 0, 8'h00, 1'b0, "after_rst");

    // Random frames against the model
    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 6));
      d  = 8'($urandom);
      case ($urandom_range(0, 6))
        0: n = 14;
        1: n = 15;
        2: n = 17;
        default: n = 16;
      endcase
      model(rw, a, d, n, ep, ee, erd);
      run_frame(rw, a, d, n, ep, ee, erd, (!rw && n == 16), $sformatf("rnd%0d", k));
    end

`ifdef SPI_BURST_EN
    // Burst write of three words starting at addr 3, wrapping past the last register
    n_pulse = 0;
    n_err   = 0;
    cs_low();
    shift_bits(64'({1'b1, 7'h03, 8'h11, 8'h22, 8'h33}), 32, rx);
    cs_high();
    mregs[3] = 8'h11;
    mregs[4] = 8'h22;
    mregs[0] = 8'h33;
    check("burst.wr_pulses", 64'(n_pulse), 64'(3));
    check("burst.frame_errs", 64'(n_err), 64'(0));
    check("burst.wr_addr", 64'(last_wa), 64'(0));
    check("burst.regs", 64'(regs_flat), 64'(packm()));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
